// File: rtl/systolic_array.sv
// ----------------------------------------------------------------------------
// systolic_array
//   DIM x DIM output-stationary systolic multiply-accumulate grid.
//   A operands enter on the left and move one column right per enabled cycle.
//   B operands enter at the top and move one row down per enabled cycle.
//   Each PE adds the product of its incoming a/b pair into a local accumulator.
//   Accumulators are loaded and read one row at a time through Crow.
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset, clears operands and accumulators
//   en     : advance the grid (shift A right, B down, accumulate)
//   WrEn   : load accumulator row Crow from Cin (takes priority over accumulate)
//   Crow   : row select for both load and read
//   A      : A[r] feeds PE(r,0), signed BITS_AB
//   B      : B[c] feeds PE(0,c), signed BITS_AB
//   Cin    : Cin[c] is loaded into PE(Crow,c), signed BITS_C
//   Cout   : Cout[c] is the accumulator of PE(Crow,c), combinational
// ----------------------------------------------------------------------------
module systolic_array #(
   parameter int BITS_AB = 8,
   parameter int BITS_C  = 16,
   parameter int DIM     = 8,
   localparam int CW     = (DIM > 1) ? $clog2(DIM) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           en,
   input  logic                           WrEn,
   input  logic [CW-1:0]                  Crow,
   input  logic [DIM-1:0][BITS_AB-1:0]    A,
   input  logic [DIM-1:0][BITS_AB-1:0]    B,
   input  logic [DIM-1:0][BITS_C-1:0]     Cin,
   output logic [DIM-1:0][BITS_C-1:0]     Cout
);

   // a_link[r][c] / b_link[r][c] are the operands arriving at PE(r,c) this cycle:
   // the grid inputs on the edges, the neighbour's registered operand inside.
   logic [DIM-1:0][DIM-1:0][BITS_AB-1:0] a_link;
   logic [DIM-1:0][DIM-1:0][BITS_AB-1:0] b_link;
   logic [DIM-1:0][DIM-1:0][BITS_C-1:0]  acc_all;
   logic [DIM-1:0]                       row_load;

   genvar gi, gj;

   generate
      for (gi = 0; gi < DIM; gi++) begin : g_edge
         assign a_link[gi][0] = A[gi];
         assign b_link[0][gi] = B[gi];
         // Crow values beyond DIM-1 match no row, so they load nothing.
         assign row_load[gi]  = WrEn && (Crow == CW'(gi));
      end

      for (gi = 0; gi < DIM; gi++) begin : g_row
         for (gj = 0; gj < DIM; gj++) begin : g_pe
            logic signed [BITS_AB-1:0]   a_in;
            logic signed [BITS_AB-1:0]   b_in;
            logic signed [2*BITS_AB-1:0] prod;
            logic signed [BITS_C-1:0]    acc_d;
            logic signed [BITS_C-1:0]    acc_q;

            assign a_in = a_link[gi][gj];
            assign b_in = b_link[gi][gj];
            // Widen before multiplying so the full signed product is kept.
            assign prod = (2*BITS_AB)'(a_in) * (2*BITS_AB)'(b_in);

            // Accumulate from the incoming operands, not the registered ones.
            // A row load overrides the accumulate of that row only.
            always_comb begin
               acc_d = acc_q;
               if (row_load[gi]) begin
                  acc_d = Cin[gj];
               end else if (en) begin
                  acc_d = acc_q + BITS_C'(prod);
               end
            end

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  acc_q <= '0;
               end else begin
                  acc_q <= acc_d;
               end
            end

            assign acc_all[gi][gj] = acc_q;

            // Forwarding registers exist only where a neighbour consumes them;
            // the last column's a_reg and last row's b_reg would never be read.
            if (gj < DIM-1) begin : g_a_fwd
               logic [BITS_AB-1:0] a_d;
               logic [BITS_AB-1:0] a_q;

               always_comb begin
                  a_d = a_q;
                  if (en) begin
                     a_d = a_in;
                  end
               end

               always_ff @(posedge clk or negedge rst_n) begin
                  if (!rst_n) begin
                     a_q <= '0;
                  end else begin
                     a_q <= a_d;
                  end
               end

               assign a_link[gi][gj+1] = a_q;
            end

            if (gi < DIM-1) begin : g_b_fwd
               logic [BITS_AB-1:0] b_d;
               logic [BITS_AB-1:0] b_q;

               always_comb begin
                  b_d = b_q;
                  if (en) begin
                     b_d = b_in;
                  end
               end

               always_ff @(posedge clk or negedge rst_n) begin
                  if (!rst_n) begin
                     b_q <= '0;
                  end else begin
                     b_q <= b_d;
                  end
               end

               assign b_link[gi+1][gj] = b_q;
            end
         end
      end
   endgenerate

   // Row read mux; an out-of-range Crow reads zero.
   always_comb begin
      Cout = '0;
      for (int r = 0; r < DIM; r++) begin
         if (Crow == CW'(r)) begin
            Cout = acc_all[r];
         end
      end
   end

endmodule
